// File: rtl/vga_rst_pkg.sv
// Shared definitions for the VGA reset sequencer: FSM state encoding and the
// layout of the optional status registers.
package vga_rst_pkg;

  typedef enum logic [2:0] {
    ST_ASSERT    = 3'd0,
    ST_HOLD      = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4,
    ST_ERROR     = 3'd5
  } vga_rst_state_e;

  localparam logic [1:0] ADDR_STATUS    = 2'd0;
  localparam logic [1:0] ADDR_LOCK_LOSS = 2'd1;

  localparam int STAT_RST_OUT_BIT  = 0;
  localparam int STAT_FRAME_EN_BIT = 1;
  localparam int STAT_TIMEOUT_BIT  = 2;
  localparam int STAT_STATE_LSB    = 4;

  // Register-map decode; unmapped addresses read as zero.
  function automatic logic [31:0] status_read(
    input logic [1:0]     addr,
    input vga_rst_state_e st,
    input logic           timeout,
    input logic           frame_en,
    input logic           rst_out,
    input logic [15:0]    lock_loss
  );
    logic [31:0] w;
    w = '0;
    case (addr)
      ADDR_STATUS: begin
        w[STAT_STATE_LSB +: 3]  = st;
        w[STAT_TIMEOUT_BIT]     = timeout;
        w[STAT_FRAME_EN_BIT]    = frame_en;
        w[STAT_RST_OUT_BIT]     = rst_out;
      end
      ADDR_LOCK_LOSS: w[15:0] = lock_loss;
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/vga_reset_sequencer_if.sv
// Avalon-MM status slave bus of the VGA reset sequencer (zero-wait reads).
interface vga_reset_sequencer_if;
  logic [1:0]  address;
  logic        read;
  logic [31:0] readdata;

  modport master (output address, output read, input readdata);
  modport slave  (input address, input read, output readdata);
endinterface

// File: rtl/vga_rst_sync2.sv
// Two-flop synchroniser for the asynchronous pixel-PLL lock indication.
module vga_rst_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/vga_reset_sequencer.sv
// Sequences the VGA pipeline reset around software reset and pixel-PLL lock.
// Define VGA_RST_STATUS_EN to add the status slave and the lock-loss counter.
module vga_reset_sequencer
  import vga_rst_pkg::*;
#(
  parameter int HOLD_CYCLES  = 16,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_reset,
  input  logic pll_locked,
  output logic vga_reset_out,
  output logic frame_gen_en,
  output logic timeout_err
`ifdef VGA_RST_STATUS_EN
  ,
  vga_reset_sequencer_if.slave status
`endif
);

  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] LOCK_LAST = 16'(LOCK_TIMEOUT - 1);

  logic           pll_locked_s;
  vga_rst_state_e state_q, state_d;
  logic [15:0]    cnt_q, cnt_d;
  logic           vga_reset_out_q;
  logic           frame_gen_en_q;
  logic           timeout_err_q;

  vga_rst_sync2 u_sync (
    .clk (clk),
    .rst (reset),
    .d_i (pll_locked),
    .q_o (pll_locked_s)
  );

  always_comb begin
    state_d = state_q;
    if (sw_reset) begin
      state_d = ST_ASSERT;
    end else begin
      case (state_q)
        ST_ASSERT:    state_d = ST_HOLD;
        ST_HOLD:      if (cnt_q == HOLD_LAST) state_d = ST_WAIT_LOCK;
        ST_WAIT_LOCK: begin
          if (pll_locked_s)            state_d = ST_RELEASE;
          else if (cnt_q == LOCK_LAST) state_d = ST_ERROR;
        end
        ST_RELEASE:   state_d = ST_RUN;
        ST_RUN:       if (!pll_locked_s) state_d = ST_ASSERT;
        ST_ERROR:     state_d = ST_ERROR;
        default:      state_d = ST_ASSERT;
      endcase
    end
  end

  // One counter serves both HOLD and WAIT_LOCK; any state change clears it.
  always_comb begin
    cnt_d = '0;
    if (state_d == state_q && (state_q == ST_HOLD || state_q == ST_WAIT_LOCK))
      cnt_d = cnt_q + 16'd1;
  end

  // Outputs are registered from the next state so they track state_q exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_ASSERT;
      cnt_q           <= '0;
      vga_reset_out_q <= 1'b1;
      frame_gen_en_q  <= 1'b0;
      timeout_err_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      vga_reset_out_q <= !(state_d == ST_RELEASE || state_d == ST_RUN);
      frame_gen_en_q  <= (state_d == ST_RUN);
      if (state_d == ST_ERROR && state_q != ST_ERROR)
        timeout_err_q <= 1'b1;
      else if (state_q == ST_ERROR && sw_reset)
        timeout_err_q <= 1'b0;
    end
  end

  assign vga_reset_out = vga_reset_out_q;
  assign frame_gen_en  = frame_gen_en_q;
  assign timeout_err   = timeout_err_q;

`ifdef VGA_RST_STATUS_EN
  logic [15:0] lock_loss_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      lock_loss_q <= '0;
    else if (state_q == ST_RUN && !sw_reset && !pll_locked_s && lock_loss_q != 16'hFFFF)
      lock_loss_q <= lock_loss_q + 16'd1;
  end

  always_comb begin
    status.readdata = '0;
    if (status.read)
      status.readdata = status_read(status.address, state_q, timeout_err_q,
                                    frame_gen_en_q, vga_reset_out_q, lock_loss_q);
  end
`endif

endmodule

// File: doc/vga_reset_sequencer.md
VGA_RESET_SEQUENCER -- requirements
Module: vga_reset_sequencer

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 16: minimum cycles vga_reset_out stays high after sw_reset falls (range 2..65535).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 1024: max cycles to wait for PLL lock before error (range 2..65535).
REQ-003 SHALL have port clk, input, 1: single clock for all logic.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port sw_reset, input, 1: software reset bit from the Avalon PIO output port, synchronous to clk.
REQ-006 SHALL have port pll_locked, input, 1: pixel-PLL lock, asynchronous to clk.
REQ-007 SHALL have port vga_reset_out, output, 1: active-high reset to the VGA pipeline.
REQ-008 SHALL have port frame_gen_en, output, 1: enable to the frame generator.
REQ-009 SHALL have port timeout_err, output, 1: sticky lock-timeout flag.

Function
REQ-010 SHALL pass pll_locked through a 2-flop synchroniser; pll_locked_s denotes its output.
REQ-011 SHALL implement the states ASSERT, HOLD, WAIT_LOCK, RELEASE, RUN and ERROR, encoded 0..5 in that order.
REQ-012 ASSERT SHALL drive vga_reset_out=1 and go to HOLD with hold counter cleared on the first cycle sw_reset=0.
REQ-013 HOLD SHALL drive vga_reset_out=1, increment hold counter each cycle, and go to WAIT_LOCK when the counter equals HOLD_CYCLES-1.
REQ-014 WAIT_LOCK SHALL drive vga_reset_out=1, go to RELEASE when pll_locked_s=1, and otherwise go to ERROR when its counter equals LOCK_TIMEOUT-1.
REQ-015 Entering ERROR SHALL set timeout_err=1; ERROR SHALL hold vga_reset_out=1 until sw_reset=1, then go to ASSERT.
REQ-016 RELEASE SHALL drive vga_reset_out=0 and frame_gen_en=0 for exactly one cycle, then go to RUN.
REQ-017 RUN SHALL drive vga_reset_out=0 and frame_gen_en=1.
REQ-018 RUN SHALL go to ASSERT when pll_locked_s=0, and SHALL increment a 16-bit lock_loss_count that saturates at 0xFFFF.
REQ-019 sw_reset=1 in any state other than ERROR SHALL force ASSERT on the next edge; this has priority over all other transitions.
REQ-020 timeout_err SHALL clear on the cycle sw_reset rises in ERROR.
REQ-021 Outputs SHALL be registered and decoded from the state register; vga_reset_out SHALL be glitch-free.

Reset
REQ-022 On reset=1 the block SHALL immediately enter ASSERT and set vga_reset_out=1, frame_gen_en=0, timeout_err=0, lock_loss_count=0, all counters=0 and synchroniser=0.
REQ-023 Reset asserted mid-sequence SHALL abort the sequence with no intermediate output pulse.

Configuration
REQ-024 With VGA_RST_STATUS_EN defined, the block SHALL add an Avalon-MM slave: address[1:0] in, read in, readdata[31:0] out, zero-wait, combinational readdata.
REQ-025 With VGA_RST_STATUS_EN: addr 0 SHALL read {25'b0, state[2:0], 1'b0, timeout_err, frame_gen_en, vga_reset_out}; addr 1 SHALL read {16'b0, lock_loss_count}; addr 2-3 SHALL read 0.
REQ-026 Without VGA_RST_STATUS_EN, the slave ports and lock_loss_count SHALL be absent, with no other behavioural change.

Structure
REQ-027 A shared package vga_rst_pkg SHALL hold the state enum, status register addresses and bit positions.
REQ-028 The synchroniser SHALL be a sub-module, vga_rst_sync2.

Verification (HOLD_CYCLES=16, LOCK_TIMEOUT=64)
REQ-029 Release reset with sw_reset=0 and pll_locked=1 -> vga_reset_out falls 16 hold + 2 sync + 1 cycles later (±1); frame_gen_en rises one cycle after that.
REQ-030 sw_reset pulse of 1 cycle during RUN -> vga_reset_out=1 on the next edge, then the full HOLD sequence repeats.
REQ-031 pll_locked held 0 -> after 64 WAIT_LOCK cycles timeout_err=1 and state=5; sw_reset pulse -> timeout_err=0 and the sequence restarts.
REQ-032 pll_locked drops for 10 cycles in RUN -> vga_reset_out=1 and lock_loss_count=1, then re-release after lock returns.
REQ-033 Assert reset at HOLD count 7 -> vga_reset_out stays 1 and the counter reads 0 after reset.
REQ-034 With VGA_RST_STATUS_EN, read addr 0 in RUN -> 0x00000042; read addr 3 -> 0x00000000.
